// File: rtl/flit_assembler_if.sv
// flit_assembler_if
//   Bundles the two handshakes around the flit assembler:
//     flit side : i_flit_in / i_flit_valid_in -> o_flit_ready_out
//     word side : o_data_out / o_valid_out    <- i_ready_in
//     status    : o_proto_err (one-cycle pulse)
//   Valid/ready semantics (both sides): a transfer happens on a rising
//   clock edge where valid && ready are both high.  Once valid is raised
//   with data, both stay unchanged until that transfer.  Ready may depend
//   combinationally on the consumer's own ready, but never on the
//   producer's valid.
//   Modports: slave = the assembler's view, master = the environment's
//   view (router egress plus downstream translator).
interface flit_assembler_if #(
  parameter int FLIT_WIDTH = 150,
  parameter int WIDTH_OUT  = 600
);
  logic [FLIT_WIDTH-1:0] i_flit_in;
  logic                  i_flit_valid_in;
  logic                  o_flit_ready_out;
  logic [WIDTH_OUT-1:0]  o_data_out;
  logic                  o_valid_out;
  logic                  i_ready_in;
  logic                  o_proto_err;

  modport slave (
    input  i_flit_in, i_flit_valid_in, i_ready_in,
    output o_flit_ready_out, o_data_out, o_valid_out, o_proto_err
  );

  modport master (
    output i_flit_in, i_flit_valid_in, i_ready_in,
    input  o_flit_ready_out, o_data_out, o_valid_out, o_proto_err
  );
endinterface

// File: rtl/flit_assembler.sv
// flit_assembler
//   Packs up to four NoC flits into one wide word for the NoC-to-Avalon-ST
//   output translator.  The first flit of a word lands in the top quarter;
//   slots left unused by a short packet are zero.
//   Ports:
//     clk        - sole clock, rising edge
//     rst_n      - asynchronous active-low reset
//     bus        - flit_assembler_if.slave (flit in, word out, proto_err)
//     dbg_state  - current FSM state (0 = COLLECT, 1 = HOLD)
//   Flit layout: [FLIT_WIDTH-1] valid, [FLIT_WIDTH-2] head,
//   [FLIT_WIDTH-3] tail, remainder carried opaquely.
module flit_assembler #(
  parameter int FLIT_WIDTH     = 150,
  parameter int FLITS_PER_WORD = 4,
  parameter int WIDTH_OUT      = FLIT_WIDTH * FLITS_PER_WORD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  flit_assembler_if.slave        bus,
  output logic                   dbg_state
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            slot_q, slot_d;
  logic [FLIT_WIDTH-1:0] buf_q [FLITS_PER_WORD];
  logic [FLIT_WIDTH-1:0] buf_d [FLITS_PER_WORD];
  logic                  err_q, err_d;

  logic flit_ready;
  logic accept;
  logic is_head;
  logic is_tail;

  // In HOLD a flit can only be taken in the cycle the word leaves, so the
  // flit-side ready simply mirrors the translator's ready.
  assign flit_ready = (state_q == COLLECT) | bus.i_ready_in;
  // A flit whose own valid bit is clear is consumed but never stored.
  assign accept     = bus.i_flit_valid_in & flit_ready & bus.i_flit_in[FLIT_WIDTH-1];
  assign is_head    = bus.i_flit_in[FLIT_WIDTH-2];
  assign is_tail    = bus.i_flit_in[FLIT_WIDTH-3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      slot_q  <= 2'd0;
      err_q   <= 1'b0;
      for (int k = 0; k < FLITS_PER_WORD; k++) buf_q[k] <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      err_q   <= err_d;
      for (int k = 0; k < FLITS_PER_WORD; k++) buf_q[k] <= buf_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    err_d   = 1'b0;
    for (int k = 0; k < FLITS_PER_WORD; k++) buf_d[k] = buf_q[k];

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (is_head && (slot_q != 2'd0)) begin
            // Previous packet never sent its tail: drop the partial word
            // and restart with this head in slot 0.
            err_d = 1'b1;
            for (int k = 0; k < FLITS_PER_WORD; k++) buf_d[k] = '0;
            buf_d[0] = bus.i_flit_in;
            if (is_tail) begin
              state_d = HOLD;
              slot_d  = 2'd0;
            end else begin
              slot_d  = 2'd1;
            end
          end else begin
            buf_d[slot_q] = bus.i_flit_in;
            if (is_tail || (slot_q == 2'd3)) begin
              state_d = HOLD;
              slot_d  = 2'd0;
            end else begin
              slot_d  = slot_q + 2'd1;
            end
          end
        end
      end

      HOLD: begin
        if (bus.i_ready_in) begin
          // Word leaves this cycle; a flit arriving now starts the next
          // word without a bubble.
          for (int k = 0; k < FLITS_PER_WORD; k++) buf_d[k] = '0;
          state_d = COLLECT;
          slot_d  = 2'd0;
          if (accept) begin
            buf_d[0] = bus.i_flit_in;
            if (is_tail) begin
              state_d = HOLD;
            end else begin
              slot_d  = 2'd1;
            end
          end
        end
      end

      default: begin
        state_d = COLLECT;
        slot_d  = 2'd0;
      end
    endcase
  end

  for (genvar k = 0; k < FLITS_PER_WORD; k++) begin : g_pack
    assign bus.o_data_out[WIDTH_OUT-1-k*FLIT_WIDTH -: FLIT_WIDTH] = buf_q[k];
  end

  // Valid comes straight from the state register so reset drops it at once.
  assign bus.o_valid_out      = (state_q == HOLD);
  assign bus.o_flit_ready_out = flit_ready;
  assign bus.o_proto_err      = err_q;
  assign dbg_state            = state_q;

endmodule

// File: doc/flit_assembler.md
Name: flit_assembler

Overview:
- Sits directly upstream of the NoC-to-Avalon-ST output translator.
- Takes one NoC flit per cycle from the router egress port and packs up to 4 flits into one 4-flit-wide word, first flit in the top quarter.
- Drives the translator's wide data/valid input and honours its ready.
- Handles packets shorter than 4 flits, zero-filling the unused slots.

Parameters:
- FLIT_WIDTH, 150, width of one NoC flit. Bit FLIT_WIDTH-1 = flit valid, FLIT_WIDTH-2 = head, FLIT_WIDTH-3 = tail; the rest is VC/dest/payload and is carried opaquely.
- FLITS_PER_WORD, 4, flits per output word. Fixed at 4; WIDTH_OUT = FLIT_WIDTH*FLITS_PER_WORD = 600.

Ports:
- clk  input  1  sole clock; all state on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_flit_in  input  FLIT_WIDTH  flit from router egress.
- i_flit_valid_in  input  1  router presents a flit.
- o_flit_ready_out  output  1  assembler accepts a flit this cycle.
- o_data_out  output  WIDTH_OUT  assembled word; slot k occupies bits [WIDTH_OUT-1-k*FLIT_WIDTH -: FLIT_WIDTH].
- o_valid_out  output  1  word valid to the translator.
- i_ready_in  input  1  translator ready.
- o_proto_err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (async assert, sync release): state=COLLECT, slot=0, buffer all-zero, o_valid_out=0, o_proto_err=0, o_flit_ready_out=1 after release.
- Accept condition: i_flit_valid_in && o_flit_ready_out && i_flit_in[FLIT_WIDTH-1].
- A flit with its valid bit (FLIT_WIDTH-1) clear is consumed and discarded. No state change.
- COLLECT state:
  - o_flit_ready_out=1 and o_valid_out=0.
  - An accepted flit is written to buffer slot `slot`.
  - If the flit's tail bit is set or slot==3: go to HOLD and reset slot to 0. Otherwise slot increments.
- HOLD state:
  - o_valid_out=1. o_data_out is stable until the handshake o_valid_out && i_ready_in.
  - Unfilled slots stay zero.
  - o_flit_ready_out equals i_ready_in (pass-through).
  - Handshake with no flit accepted: buffer cleared, go to COLLECT.
  - Handshake with a flit accepted the same cycle: buffer cleared except slot 0, which takes the new flit. Slot becomes 1, or the state stays in HOLD if that flit has its tail bit set.
- Latency: a word is presented one cycle after its last flit is accepted.
- Throughput: sustained 1 flit/cycle when i_ready_in=1.
- Protocol error: a head flit accepted in COLLECT with slot!=0 means a missing tail.
  - The partial word is dropped.
  - The head flit is written to slot 0 and slot becomes 1.
  - o_proto_err pulses high for one cycle.
- A single-flit packet with head and tail both set produces a word with slot 0 filled and slots 1-3 zero.
- Reset asserted mid-packet or mid-HOLD: the buffer is discarded immediately and o_valid_out drops asynchronously.
- o_valid_out never deasserts without a handshake (Avalon-ST valid stability).

Test Plan:
- 4-flit packet: flits A(head), B, C, D(tail), back-to-back, with i_ready_in=1. Expect o_valid_out one cycle after D; o_data_out={A,B,C,D}; o_flit_ready_out stays 1 throughout.
- 2-flit packet: A(head), B(tail). Expect word {A,B,0,0}; bit 599 = 1, bit 598 = 1, bit 147 = 0.
- Backpressure: i_ready_in=0 for 5 cycles after the word forms. Expect o_valid_out held at 1, o_data_out unchanged, o_flit_ready_out=0. Releasing ready gives exactly one transfer.
- Pass-through: the next head flit E arrives in the handshake cycle. Expect E in slot 0 of the following word, with no bubble.
- Missing tail: A(head), B, then C(head), D(tail). Expect o_proto_err pulse on C, and the only output word is {C,D,0,0}.
- Async reset asserted while in HOLD. Expect o_valid_out=0 the same cycle. After release, a fresh packet assembles correctly with no stale slots.
